axi_burst_addr_gen: RTL

- Sequential successor to the combinational AXI next-address calculator.
- Accepts one AXI4 burst command (addr/len/size/burst/id) over a valid/ready handshake, then issues one beat descriptor per cycle: address, byte strobe, last flag and beat index.
- The descriptor stream has its own valid/ready handshake.
- Sits between the slave AW/AR channel skid buffers and the W/R datapath of the AXI slave.
- Supports FIXED, INCR (1-256 beats), WRAP (2/4/8/16 beats), narrow transfers, unaligned start and 4 KB page hold.

---
 rtl/axi_burst_addr_gen.sv | 128 ++++++++++++
 1 files changed

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: turns one AXI4 burst command into a per-cycle stream of beat descriptors.
// Optional AXI_BURST_CHK_EN adds the illegal-command checker that drives o_err.
module axi_burst_addr_gen #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int IDW = 4
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic [AW-1:0]   i_cmd_addr,
  input  logic [7:0]      i_cmd_len,
  input  logic [2:0]      i_cmd_size,
  input  logic [1:0]      i_cmd_burst,
  input  logic [IDW-1:0]  i_cmd_id,
  output logic            o_beat_valid,
  input  logic            i_beat_ready,
  output logic [AW-1:0]   o_beat_addr,
  output logic [DW/8-1:0] o_beat_strb,
  output logic            o_beat_last,
  output logic [7:0]      o_beat_idx,
  output logic [IDW-1:0]  o_beat_id,
  output logic            o_err
);
  localparam int NB  = DW / 8;
  localparam int DSZ = $clog2(NB);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t         r_state, w_state_nx;
  logic [AW-1:0]  r_addr, w_next;
  logic [7:0]     r_len, r_idx;
  logic [2:0]     r_size, w_size;
  logic [1:0]     r_burst;
  logic [IDW-1:0] r_id;
  logic           w_cmd_hs, w_beat_hs, w_last;
  logic [11:0]    w_lo, w_inc_sz, w_inc, w_mask, w_next_lo, w_off, w_cst, w_cend;

  assign o_beat_valid = r_state == S_BURST;
  assign w_last       = o_beat_valid && (r_idx == r_len);
  assign o_beat_last  = w_last;
  assign o_cmd_ready  = !o_beat_valid || (w_last && i_beat_ready);
  assign w_cmd_hs     = i_cmd_valid && o_cmd_ready;
  assign w_beat_hs    = o_beat_valid && i_beat_ready;
  assign w_size       = (i_cmd_size > 3'(DSZ)) ? 3'(DSZ) : i_cmd_size;
  assign o_beat_addr  = r_addr;
  assign o_beat_idx   = r_idx;
  assign o_beat_id    = r_id;

  always_comb begin
    w_state_nx = r_state;
    w_state_nx = w_cmd_hs ? S_BURST : (w_beat_hs && w_last) ? S_IDLE : r_state;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  // Address arithmetic stays inside the 4 KB page; upper bits are carried from the start address.
  assign w_lo      = r_addr[11:0];
  assign w_inc_sz  = 12'd1 << r_size;
  assign w_inc     = (w_lo & ~(w_inc_sz - 12'd1)) + w_inc_sz;
  assign w_mask    = 12'((16'(r_len) + 16'd1) << r_size) - 12'd1;
  assign w_next_lo = (r_burst == 2'b00) ? w_lo :
                     (r_burst == 2'b10) ? ((w_lo & ~w_mask) | (w_inc & w_mask)) : w_inc;

  always_comb begin
    w_next       = r_addr;
    w_next[11:0] = w_next_lo;
  end

  assign w_off  = w_lo & 12'(NB - 1);
  assign w_cst  = w_off & ~(w_inc_sz - 12'd1);
  assign w_cend = w_cst + w_inc_sz;

  always_comb begin
    o_beat_strb = '0;
    for (int j = 0; j < NB; j++)
      o_beat_strb[j] = o_beat_valid && (12'(j) >= w_off) && (12'(j) < w_cend);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_id    <= '0;
      r_idx   <= '0;
    end else if (w_cmd_hs) begin
      r_addr  <= i_cmd_addr;
      r_len   <= i_cmd_len;
      r_size  <= w_size;
      r_burst <= (i_cmd_burst == 2'b11) ? 2'b01 : i_cmd_burst;
      r_id    <= i_cmd_id;
      r_idx   <= '0;
    end else if (w_beat_hs && !w_last) begin
      r_addr  <= w_next;
      r_idx   <= r_idx + 8'd1;
    end
  end

`ifdef AXI_BURST_CHK_EN
  logic        r_err, w_illegal;
  logic [11:0] w_amask;
  logic [16:0] w_end;

  assign w_amask   = (12'd1 << i_cmd_size) - 12'd1;
  assign w_end     = 17'(i_cmd_addr[11:0] & ~((12'd1 << w_size) - 12'd1)) +
                     ((17'(i_cmd_len) + 17'd1) << w_size);
  assign w_illegal = (i_cmd_burst == 2'b10 && !(i_cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
                     (i_cmd_burst == 2'b10 && (i_cmd_addr[11:0] & w_amask) != 12'd0) ||
                     (i_cmd_size > 3'(DSZ)) ||
                     (i_cmd_burst[0] && w_end > 17'h1000);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                r_err <= 1'b0;
    else if (w_cmd_hs)           r_err <= w_illegal;
    else if (w_beat_hs && w_last) r_err <= 1'b0;
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif
endmodule
